seq_complementer: RTL
=====================

SEQ_COMPLEMENTER -- requirements
Module: seq_complementer

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 2: bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request a new operation; sampled on the rising edge.
REQ-006 mode  input  2  operation select, captured with start: 00 ones', 01 twos', 10 absolute value, 11 pass-through.
REQ-007 A  input  WIDTH  operand, captured with start.
REQ-008 out  output  WIDTH  registered result.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when out holds a new result.
REQ-011 ovf  output  1  set when the result is not representable (most-negative operand in twos'/abs mode).
REQ-012 zero  output  1  set when the result is all zeros.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE; N = WIDTH/DIGIT.
REQ-014 IDLE: start=1 -> capture A and mode, load carry=1, clear digit counter, go to RUN; start=0 -> stay in IDLE.
REQ-015 RUN: each cycle processes one DIGIT-bit slice, LSB slice first, and increments the digit counter.
REQ-016 RUN: after the Nth slice the FSM SHALL go to DONE.
REQ-017 Slice rule, ones' mode: result slice = ~slice.
REQ-018 Slice rule, twos' mode: result slice = ~slice + carry; carry-out is kept for the next slice; the final carry-out is discarded.
REQ-019 Slice rule, abs mode: the twos' rule if A[WIDTH-1]=1, otherwise pass-through.
REQ-020 Slice rule, pass mode: result slice = slice.
REQ-021 In the DONE state, out, ovf and zero SHALL be updated and done SHALL be 1 for exactly that cycle.
REQ-022 Latency: with start sampled at edge k, done and the new out SHALL be visible after edge k+N+1; out, ovf and zero SHALL hold their previous values until then.
REQ-023 DONE with start=1: a new operation SHALL be captured (go to RUN); the sustained issue rate is one result every N+1 cycles.
REQ-024 DONE with start=0: the FSM SHALL go to IDLE.
REQ-025 start while in RUN SHALL be ignored; the operation in flight and its captured operands SHALL be unaffected.
REQ-026 busy SHALL be 1 exactly while in RUN.
REQ-027 ovf SHALL be 1 only when mode is 01 or 10 and A = 1 followed by WIDTH-1 zeros; out then equals A. ovf SHALL be 0 otherwise.
REQ-028 Boundary values: ones' of 0 SHALL give all ones; twos' of 0 SHALL give 0 with zero=1 and ovf=0.
REQ-029 A and mode changing after capture SHALL have no effect on the operation in flight.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE and set out=0, busy=0, done=0, ovf=0, zero=0, carry=0 and digit counter=0.
REQ-031 rst SHALL take priority over start.
REQ-032 rst asserted mid-RUN SHALL abort the operation, and no done pulse SHALL follow.
REQ-033 The first start after rst deasserts SHALL be accepted normally.

Verification (WIDTH=8, DIGIT=2 unless stated; N=4)
REQ-034 mode=00, A=0xA5, start pulse -> busy for 4 cycles, then done=1 with out=0x5A, zero=0, ovf=0.
REQ-035 mode=01, A=0x01 -> out=0xFF; then mode=01, A=0x00 -> out=0x00, zero=1, ovf=0.
REQ-036 mode=01, A=0x80 -> out=0x80, ovf=1; mode=10, A=0xF6 -> out=0x0A; mode=10, A=0x05 -> out=0x05, ovf=0.
REQ-037 start held high continuously with A changing every cycle -> done pulses every 5 cycles; each result matches the A captured at its accepting edge; mid-RUN starts are ignored.
REQ-038 rst asserted in the 2nd RUN cycle of mode=01, A=0x33 -> next cycle: state IDLE, out=0, busy=0; no done pulse for 10 cycles.
REQ-039 WIDTH=4, DIGIT=1: mode=01, A=1010 -> out=0110 after 4 RUN cycles; mode=01, A=1111 -> out=0001; mode=00, A=0000 -> out=1111.

Source files
------------

// File: rtl/seq_complementer.sv
// Digit-serial complementer. It processes the captured operand DIGIT bits per
// clock, LSB slice first. The modes are ones' complement, twos' complement,
// absolute value and pass-through. The result, ovf and zero are registered and
// change only on the cycle that follows the DONE state.
//
// Handshake: start is sampled on every rising edge. It is accepted only in
// IDLE or DONE, and that same edge captures A and mode. start in RUN is
// ignored. done is a one-cycle pulse that marks the cycle in which out, ovf
// and zero first show the new result. busy is high exactly while in RUN.
module seq_complementer #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       fsm_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;      // captured operand, shifted right one slice per RUN cycle
  logic [WIDTH-1:0] res;       // result, filled from the top one slice per RUN cycle
  logic             neg_r;     // slice rule is ~slice + carry
  logic             inv_r;     // slice rule is ~slice
  logic             carry;
  logic             ovf_pend;
  logic [CW-1:0]    cnt;

  logic                   capture;
  logic                   last_slice;
  logic [DIGIT-1:0]       slice;
  logic [DIGIT:0]         sum;
  logic [DIGIT-1:0]       res_slice;
  logic [WIDTH+DIGIT-1:0] res_wide;
  logic [WIDTH+DIGIT-1:0] res_shift;
  logic [WIDTH-1:0]       res_next;

  assign capture    = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_slice = (cnt == CW'(N - 1));

  // Slice datapath: pick the rule for this slice and build the next shifted result.
  always_comb begin
    slice     = a_sh[DIGIT-1:0];
    sum       = {1'b0, ~slice} + {{DIGIT{1'b0}}, carry};
    res_slice = slice;
    if (neg_r) begin
      res_slice = sum[DIGIT-1:0];
    end else if (inv_r) begin
      res_slice = ~slice;
    end
    res_wide  = {res_slice, res};
    res_shift = res_wide >> DIGIT;
    res_next  = res_shift[WIDTH-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = start ? S_RUN : S_IDLE;
      S_RUN:   state_next = last_slice ? S_DONE : S_RUN;
      S_DONE:  state_next = start ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: busy, plus the raw state for observation.
  always_comb begin
    busy      = (state == S_RUN);
    fsm_state = state;
  end

  // Operand capture, per-slice processing and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      res      <= '0;
      neg_r    <= 1'b0;
      inv_r    <= 1'b0;
      carry    <= 1'b0;
      ovf_pend <= 1'b0;
      cnt      <= '0;
      out      <= '0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      if (state == S_DONE) begin
        out  <= res;
        ovf  <= ovf_pend;
        zero <= (res == '0);
      end
      if (capture) begin
        a_sh     <= A;
        inv_r    <= (mode == 2'b00);
        neg_r    <= (mode == 2'b01) || ((mode == 2'b10) && A[WIDTH-1]);
        ovf_pend <= ((mode == 2'b01) || (mode == 2'b10)) && (A == MOST_NEG);
        carry    <= 1'b1;
        cnt      <= '0;
      end else if (state == S_RUN) begin
        a_sh  <= a_sh >> DIGIT;
        res   <= res_next;
        carry <= sum[DIGIT];
        cnt   <= cnt + CW'(1);
      end
    end
  end

endmodule
